sa_ram_rd_streamer: RTL

Read-side client for the 256x7 two-port sa_ram models. It accepts a burst command (start address, length) and issues sequential ram_re/ram_ra reads. It absorbs the RAM's one-cycle registered-address read latency and presents the data as a valid/ready stream with full backpressure. It sits between a sa_ram_rws_* instance's read port and a downstream consumer; the write port stays with the producer.

---
 rtl/sa_ram_pkg.sv | 21 ++
 rtl/sa_rd_skid_fifo.sv | 53 +++++
 rtl/sa_ram_rd_streamer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/sa_ram_pkg.sv
// Shared types for the sa_ram read-side streamer: default geometry,
// streamer FSM encoding and the skid-buffer entry layout.
package sa_ram_pkg;

    localparam int AW_DEF = 8;
    localparam int DW_DEF = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

    // Buffer entry at the default data width; the streamer builds the same
    // {last, data} layout at whatever DW it is instantiated with.
    typedef struct packed {
        logic              last;
        logic [DW_DEF-1:0] data;
    } rd_entry_t;

endpackage

// File: rtl/sa_rd_skid_fifo.sv
// Small register FIFO that absorbs read data returning from the RAM.
// Head entry is presented combinationally; reads as zero when empty.
module sa_rd_skid_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] cnt
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wp;
    logic [PW-1:0] rp;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == LAST_IDX) ? '0 : p + PW'(1);
    endfunction

    // Storage write; contents need no reset since dout is gated by cnt.
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= din;
    end

    // Pointer and occupancy bookkeeping; push+pop together leaves cnt as is.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) wp <= nxt(wp);
            if (pop)  rp <= nxt(rp);
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign dout = (cnt != '0) ? mem[rp] : '0;

endmodule

// File: rtl/sa_ram_rd_streamer.sv
// Burst reader for the 256x7 two-port sa_ram: takes {addr, len} commands,
// issues sequential reads, hides the one-cycle registered-address read
// latency and streams the data out as valid/ready with full backpressure.
module sa_ram_rd_streamer
    import sa_ram_pkg::*;
#(
    parameter int AW        = AW_DEF,
    parameter int DW        = DW_DEF,
    parameter int BUF_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [AW-1:0] cmd_addr,
    input  logic [AW-1:0] cmd_len,
    output logic          ram_re,
    output logic [AW-1:0] ram_ra,
    input  logic [DW-1:0] ram_dout,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          busy
);

    localparam int CW = $clog2(BUF_DEPTH + 1);
    // Two spare bits so cnt + p1 never overflows before the compare.
    localparam logic [CW+1:0] DEPTH_V = (CW + 2)'(BUF_DEPTH);

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } entry_t;

    rd_state_t     state;
    logic [AW-1:0] addr_q;
    logic [AW-1:0] rem_q;
    logic          p1;
    logic          p1_last;
    logic [CW-1:0] cnt;
    logic          pop;
    logic [CW+1:0] proj;
    entry_t        push_e;
    entry_t        head_e;

    assign pop = out_valid & out_ready;

    // Occupancy the buffer will have after this edge, counting the beat
    // already on ram_dout. pop implies cnt>0, so this cannot underflow.
    always_comb begin
        proj = {2'b00, cnt} + {{(CW + 1){1'b0}}, p1} - {{(CW + 1){1'b0}}, pop};
    end

    // Reads are issued only while a slot is guaranteed for the returning data.
    assign ram_re = (state == READ) && (proj < DEPTH_V);
    assign ram_ra = addr_q;

    // Command FSM: latch burst, walk addresses, wait for the last beat to leave.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        addr_q    <= cmd_addr;
                        rem_q     <= cmd_len;
                        state     <= READ;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                READ: begin
                    if (ram_re) begin
                        addr_q <= addr_q + AW'(1);
                        rem_q  <= rem_q - AW'(1);
                        if (rem_q == '0) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && out_last) begin
                        state     <= IDLE;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    // Track the read in flight so its data is captured on the next cycle,
    // tagged with whether it was the burst's final read.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            p1      <= 1'b0;
            p1_last <= 1'b0;
        end else begin
            p1      <= ram_re;
            p1_last <= ram_re && (rem_q == '0);
        end
    end

    assign push_e.last = p1_last;
    assign push_e.data = ram_dout;

    sa_rd_skid_fifo #(
        .W     ($bits(entry_t)),
        .DEPTH (BUF_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk  (clk),
        .rstn (rstn),
        .push (p1),
        .din  (push_e),
        .pop  (pop),
        .dout (head_e),
        .cnt  (cnt)
    );

    assign out_valid = (cnt != '0);
    assign out_data  = head_e.data;
    assign out_last  = head_e.last;

endmodule
